// File: rtl/memory_pipe.sv
// memory_pipe: 1R/1W word memory with self-clear after reset and RD_LAT-stage read pipe.
// Build option: define MEM_FWD_EN for write-first collision reads (default is read-first).
module memory_pipe #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 128,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   typedef struct packed {
      logic              v;
      logic              e;
      logic [DATA_W-1:0] d;
   } stage_t;

   state_t            state_q;
   state_t            state_d;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  ptr_d;
   logic              clr_en;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_hit;
   logic              rd_acc;
   logic              rd_oob;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  m_idx;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] rd_word;

   stage_t            st [RD_LAT];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      clr_en   = 1'b0;
      busy     = 1'b0;
      rd_ready = 1'b0;
      unique case (state_q)
         S_INIT: begin
            busy   = 1'b1;
            clr_en = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == LAST) begin
               state_d = S_RUN;
               ptr_d   = '0;
            end
         end
         S_RUN: begin
            rd_ready = 1'b1;
         end
         default: ;
      endcase
   end

   // Range checks widen by one bit so high address bits are never dropped.
   assign wr_hit = (state_q == S_RUN) && wr_en && ({1'b0, wr_addr} < LIM);
   assign rd_oob = !({1'b0, rd_addr} < LIM);
   assign rd_acc = rd_valid && rd_ready;
   assign wr_idx = wr_addr[IDX_W-1:0];
   assign rd_idx = rd_addr[IDX_W-1:0];

   assign m_idx  = clr_en ? ptr_q : wr_idx;
   assign m_data = clr_en ? '0 : wr_data;

   always_ff @(posedge clk) begin
      if (reset_n && (clr_en || wr_hit)) begin
         mem[m_idx] <= m_data;
      end
   end

`ifdef MEM_FWD_EN
   logic coll;
   assign coll    = wr_hit && !rd_oob && (wr_idx == rd_idx);
   assign rd_word = coll ? wr_data : mem[rd_idx];
`else
   assign rd_word = mem[rd_idx];
`endif

   // Data/err only move with a valid so the outputs hold between pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < RD_LAT; k++) begin
            st[k] <= '0;
         end
      end else begin
         st[0].v <= rd_acc;
         if (rd_acc) begin
            st[0].e <= rd_oob;
            st[0].d <= rd_oob ? '0 : rd_word;
         end
         for (int k = 1; k < RD_LAT; k++) begin
            st[k].v <= st[k-1].v;
            if (st[k-1].v) begin
               st[k].e <= st[k-1].e;
               st[k].d <= st[k-1].d;
            end
         end
      end
   end

   assign rsp_valid = st[RD_LAT-1].v;
   assign rsp_err   = st[RD_LAT-1].e;
   assign rsp_data  = st[RD_LAT-1].d;

endmodule
